neuron_input_buffer: RTL and testbench
======================================

Name: neuron_input_buffer

Overview:
Upstream stage of the neuron datapath. Accepts a serial valid/ready stream of signed samples and assembles them into a NUM_INPUTS-wide parallel vector. When the vector is full it raises input_ready and holds the vector stable until the consuming neuron reports completion. This lets one serial source (e.g. a pixel stream) feed the neuron's parallel multiply array.

Parameters:
DATA_WIDTH, 32, width of each signed sample.
NUM_INPUTS, 16, samples per frame; must be >= 2.

Ports:
clock  input  1  system clock.
reset  input  1  reset, asynchronous, active-high.
clear  input  1  synchronous abort: flush the frame and return to FILL.
in_valid  input  1  upstream sample valid.
in_data  input  DATA_WIDTH signed  upstream sample.
in_last  input  1  upstream end-of-frame marker; used only with the optional feature.
in_ready  output  1  buffer can accept a sample this cycle.
inputs  output  NUM_INPUTS x DATA_WIDTH signed (unpacked array)  assembled vector to the neuron.
input_ready  output  1  vector complete and stable.
consumer_done  input  1  neuron finished (driven by the neuron's output_ready).
frame_error  output  1  sticky flag: in_last was asserted on a non-final sample.

Behaviour:
- Reset values:
  - state = FILL, wr_idx = 0, all inputs[i] = 0.
  - input_ready = 0, frame_error = 0.
  - in_ready = 1 once reset deasserts.
- in_ready is combinational: 1 in FILL, 0 in LOADED.
- A sample is accepted when in_valid && in_ready. On accept:
  - inputs[wr_idx] <= in_data.
  - wr_idx increments.
  - wr_idx width is $clog2(NUM_INPUTS).
- States:
  - FILL: accept samples.
    - An accept at wr_idx == NUM_INPUTS-1 moves to LOADED next cycle and resets wr_idx to 0.
    - consumer_done is ignored in FILL.
  - LOADED:
    - input_ready = 1 (registered level, not a pulse).
    - inputs is frozen; no sample is accepted.
    - consumer_done = 1 moves to FILL next cycle and drops input_ready in that same cycle.
    - The vector is not cleared; it is overwritten word by word by the next frame.
- Latency: input_ready rises on the cycle after the final sample is accepted.
- Back-to-back frames: a new frame's first sample can be accepted on the cycle after consumer_done is sampled.
- clear:
  - Effect: next state = FILL, wr_idx = 0, all inputs zeroed, input_ready = 0.
  - Priority: over every other input except reset.
  - frame_error is also cleared by clear.
- Reset mid-frame: all state returns to reset values; any partial frame is discarded.
- in_valid deasserted mid-frame: wr_idx holds; no timeout.
- No arithmetic on data: samples are stored bit-exact with no sign extension or truncation.
- frame_error: sets when in_last is accepted with wr_idx != NUM_INPUTS-1. Only reset or clear clears it.

Optional Feature:
Macro NEURON_INPUT_BUFFER_SHORT_FRAME_EN.
- Defined:
  - An accepted in_last with wr_idx < NUM_INPUTS-1 ends the frame early.
  - Remaining positions wr_idx+1 .. NUM_INPUTS-1 are written with 0 in the same cycle.
  - The state goes to LOADED next cycle; frame_error is not set.
  - An in_last on the final sample behaves normally.
- Not defined:
  - in_last does not affect sequencing; frames always hold exactly NUM_INPUTS samples.
  - An early in_last sets frame_error only.

Decomposition:
- Shared package nn_pkg holds:
  - typedef enum logic [0:0] {FILL, LOADED} input_buffer_state_t;
  - localparam DEFAULT_DATA_WIDTH = 32;
  - localparam DEFAULT_NUM_INPUTS = 16.
- No sub-module. The index counter and vector register are small enough to stay in this module.

Test Plan:
- Stream samples 1..16 with in_valid held high → inputs[i] = i+1; input_ready = 1 exactly one cycle after the 16th accept; in_ready = 0 while LOADED.
- In LOADED, drive in_valid = 1 with data 99 for 5 cycles, then consumer_done = 1 → vector unchanged; input_ready falls the next cycle; 99 is accepted as inputs[0] of the next frame.
- Gapped stream (in_valid toggling every other cycle), values −5, −4, ... → wr_idx holds across gaps; vector is correct and signed values are preserved bit-exact.
- After 7 samples, assert clear → all inputs = 0, wr_idx = 0, input_ready stays 0; the next 16 samples form a clean frame.
- Assert reset mid-frame (after 10 samples), then in LOADED (consumer_done also high in that cycle) → outputs return to reset values immediately (asynchronous).
- in_last on the 4th sample, values 7,8,9,10:
  - With the macro: inputs = {7,8,9,10,0,...,0}, input_ready = 1 next cycle.
  - Without the macro: frame_error = 1, and the frame still needs 12 more samples.

Source files
------------

// File: rtl/neuron_input_buffer_pkg.sv
// Shared types and default sizes for the neuron datapath.
package nn_pkg;

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    LOADED = 1'b1
  } input_buffer_state_t;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_INPUTS = 16;

endpackage

// File: rtl/neuron_input_buffer.sv
// Serial-to-parallel sample buffer feeding the neuron multiply array.
// Optional short frames (early in_last zero-pads the vector): NEURON_INPUT_BUFFER_SHORT_FRAME_EN.
module neuron_input_buffer
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_INPUTS = DEFAULT_NUM_INPUTS
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] inputs [NUM_INPUTS],
  output logic                         input_ready,
  input  logic                         consumer_done,
  output logic                         frame_error
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  input_buffer_state_t state;
  logic [IDX_W-1:0]    wr_idx;
  logic                accept;
  logic                final_sample;

  assign in_ready     = (state == FILL);
  assign accept       = in_valid && in_ready;
  assign final_sample = (wr_idx == LAST_IDX);

  // Frame sequencing, write index, vector storage and status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= FILL;
      wr_idx      <= '0;
      input_ready <= 1'b0;
      frame_error <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        inputs[i] <= '0;
      end
    end else if (clear) begin
      state       <= FILL;
      wr_idx      <= '0;
      input_ready <= 1'b0;
      frame_error <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        inputs[i] <= '0;
      end
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            inputs[wr_idx] <= in_data;
`ifdef NEURON_INPUT_BUFFER_SHORT_FRAME_EN
            if (final_sample || in_last) begin
              // Pad everything past the last written slot so a short frame reads as zeros.
              for (int i = 0; i < NUM_INPUTS; i++) begin
                if (i > int'(wr_idx)) begin
                  inputs[i] <= '0;
                end
              end
              state       <= LOADED;
              wr_idx      <= '0;
              input_ready <= 1'b1;
            end else begin
              wr_idx <= wr_idx + IDX_W'(1);
            end
`else
            if (in_last && !final_sample) begin
              frame_error <= 1'b1;
            end
            if (final_sample) begin
              state       <= LOADED;
              wr_idx      <= '0;
              input_ready <= 1'b1;
            end else begin
              wr_idx <= wr_idx + IDX_W'(1);
            end
`endif
          end
        end
        LOADED: begin
          // Vector stays frozen; the next frame overwrites it slot by slot.
          if (consumer_done) begin
            state       <= FILL;
            input_ready <= 1'b0;
          end
        end
        default: begin
          state       <= FILL;
          wr_idx      <= '0;
          input_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_input_buffer.sv
// Self-checking bench for neuron_input_buffer: directed scenarios plus a randomized
// run against a queue-based frame model.
module tb_neuron_input_buffer;

  localparam int W = 32;
  localparam int N = 16;

  logic                clock = 1'b0;
  logic                reset;
  logic                clear;
  logic                in_valid;
  logic signed [W-1:0] in_data;
  logic                in_last;
  logic                in_ready;
  logic signed [W-1:0] inputs [N];
  logic                input_ready;
  logic                consumer_done;
  logic                frame_error;

  int total = 0;
  int bad = 0;
  logic signed [W-1:0] exp_vec [N];

  neuron_input_buffer #(.DATA_WIDTH(W), .NUM_INPUTS(N)) dut (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
    .in_ready(in_ready),
    .inputs(inputs),
    .input_ready(input_ready),
    .consumer_done(consumer_done),
    .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_last = 1'b0;
    clear = 1'b0;
    consumer_done = 1'b0;
    in_data = '0;
  endtask

  task automatic push(input logic signed [W-1:0] d, input logic l);
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic zero_exp();
    for (int i = 0; i < N; i++) exp_vec[i] = '0;
  endtask

  // Index of the first slot differing from exp_vec, or -1.
  function automatic int first_diff();
    for (int i = 0; i < N; i++) begin
      if (inputs[i] !== exp_vec[i]) return i;
    end
    return -1;
  endfunction

  task automatic release_frame();
    consumer_done = 1'b1;
    tick();
    consumer_done = 1'b0;
  endtask

  task automatic test_reset();
    int d;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    tick();
    zero_exp();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (input_ready !== 1'b0) begin bad++; $display("FAIL reset_input_ready got=%b want=0", input_ready); end
    total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL reset_frame_error got=%b want=0", frame_error); end
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL reset_vec idx=%0d got=%0d want=%0d", d, inputs[d], exp_vec[d]); end
  endtask

  task automatic test_full_frame();
    int d;
    in_valid = 1'b1;
    for (int k = 0; k < N; k++) begin
      in_data = W'(k + 1);
      exp_vec[k] = W'(k + 1);
      if (k == N - 1) begin
        total++; if (input_ready !== 1'b0) begin bad++; $display("FAIL full_ready_early got=%b want=0", input_ready); end
      end
      tick();
    end
    total++; if (input_ready !== 1'b1) begin bad++; $display("FAIL full_input_ready got=%b want=1", input_ready); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL full_vec idx=%0d got=%0d want=%0d", d, inputs[d], exp_vec[d]); end
  endtask

  task automatic test_loaded_hold();
    int d;
    in_valid = 1'b1;
    in_data = W'(99);
    repeat (5) tick();
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL hold_vec idx=%0d got=%0d want=%0d", d, inputs[d], exp_vec[d]); end
    total++; if (input_ready !== 1'b1) begin bad++; $display("FAIL hold_input_ready got=%b want=1", input_ready); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready got=%b want=0", in_ready); end
    consumer_done = 1'b1;
    tick();
    consumer_done = 1'b0;
    total++; if (input_ready !== 1'b0) begin bad++; $display("FAIL done_input_ready got=%b want=0", input_ready); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL done_in_ready got=%b want=1", in_ready); end
    total++; if (inputs[0] !== exp_vec[0]) begin bad++; $display("FAIL done_slot0 got=%0d want=%0d", inputs[0], exp_vec[0]); end
    tick();
    in_valid = 1'b0;
    total++; if (inputs[0] !== 32'sd99) begin bad++; $display("FAIL next_slot0 got=%0d want=99", inputs[0]); end
    total++; if (inputs[1] !== exp_vec[1]) begin bad++; $display("FAIL next_slot1 got=%0d want=%0d", inputs[1], exp_vec[1]); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    zero_exp();
  endtask

  task automatic test_gapped();
    int d;
    for (int k = 0; k < 2 * N; k++) begin
      in_valid = (k % 2 == 0);
      in_data = in_valid ? W'(-5 + k / 2) : W'(32'h5A5A5A5A);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) exp_vec[i] = W'(-5 + i);
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL gapped_vec idx=%0d got=%h want=%h", d, inputs[d], exp_vec[d]); end
    total++; if (input_ready !== 1'b1) begin bad++; $display("FAIL gapped_input_ready got=%b want=1", input_ready); end
    release_frame();
  endtask

  task automatic test_clear();
    int d;
    for (int k = 0; k < 7; k++) push(W'(100 + k), 1'b0);
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = W'(555);
    consumer_done = 1'b1;
    tick();
    idle_inputs();
    zero_exp();
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL clear_vec idx=%0d got=%0d want=%0d", d, inputs[d], exp_vec[d]); end
    total++; if (input_ready !== 1'b0) begin bad++; $display("FAIL clear_input_ready got=%b want=0", input_ready); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL clear_in_ready got=%b want=1", in_ready); end
    for (int k = 0; k < N; k++) begin
      push(W'(200 + k), 1'b0);
      exp_vec[k] = W'(200 + k);
    end
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL post_clear_vec idx=%0d got=%0d want=%0d", d, inputs[d], exp_vec[d]); end
    total++; if (input_ready !== 1'b1) begin bad++; $display("FAIL post_clear_ready got=%b want=1", input_ready); end
    release_frame();
  endtask

  task automatic test_last();
    int d;
    push(W'(7), 1'b0);
    push(W'(8), 1'b0);
    push(W'(9), 1'b0);
    push(W'(10), 1'b1);
    exp_vec[0] = W'(7); exp_vec[1] = W'(8); exp_vec[2] = W'(9); exp_vec[3] = W'(10);
`ifdef NEURON_INPUT_BUFFER_SHORT_FRAME_EN
    for (int i = 4; i < N; i++) exp_vec[i] = '0;
    total++; if (input_ready !== 1'b1) begin bad++; $display("FAIL short_input_ready got=%b want=1", input_ready); end
    total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL short_frame_error got=%b want=0", frame_error); end
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL short_vec idx=%0d got=%0d want=%0d", d, inputs[d], exp_vec[d]); end
`else
    total++; if (frame_error !== 1'b1) begin bad++; $display("FAIL last_frame_error got=%b want=1", frame_error); end
    total++; if (input_ready !== 1'b0) begin bad++; $display("FAIL last_input_ready got=%b want=0", input_ready); end
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL last_vec idx=%0d got=%0d want=%0d", d, inputs[d], exp_vec[d]); end
    for (int k = 4; k < N - 1; k++) push(W'(k + 7), 1'b0);
    total++; if (input_ready !== 1'b0) begin bad++; $display("FAIL last_ready_early got=%b want=0", input_ready); end
    push(W'(N + 6), 1'b0);
    total++; if (input_ready !== 1'b1) begin bad++; $display("FAIL last_ready_full got=%b want=1", input_ready); end
    total++; if (frame_error !== 1'b1) begin bad++; $display("FAIL last_error_sticky got=%b want=1", frame_error); end
`endif
    release_frame();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    zero_exp();
    total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL clear_frame_error got=%b want=0", frame_error); end
  endtask

  task automatic test_reset_mid();
    int d;
    for (int k = 0; k < 10; k++) push(W'(300 + k), 1'b0);
    #2 reset = 1'b1;
    #1;
    zero_exp();
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL rst_mid_vec idx=%0d got=%0d want=%0d", d, inputs[d], exp_vec[d]); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready got=%b want=1", in_ready); end
    @(posedge clock);
    #1 reset = 1'b0;
    tick();
    for (int k = 0; k < N; k++) push(W'(400 + k), 1'b0);
    total++; if (input_ready !== 1'b1) begin bad++; $display("FAIL rst_fill_ready got=%b want=1", input_ready); end
    consumer_done = 1'b1;
    #2 reset = 1'b1;
    #1;
    total++; if (input_ready !== 1'b0) begin bad++; $display("FAIL rst_loaded_ready got=%b want=0", input_ready); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_loaded_in_ready got=%b want=1", in_ready); end
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL rst_loaded_vec idx=%0d got=%0d want=%0d", d, inputs[d], exp_vec[d]); end
    @(posedge clock);
    #1 reset = 1'b0;
    consumer_done = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int d;
    logic signed [W-1:0] q [$];
    bit loaded;
    bit err;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    zero_exp();
    loaded = 1'b0;
    err = 1'b0;
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = W'($urandom);
      in_last = ($urandom_range(0, 15) == 0);
      consumer_done = ($urandom_range(0, 2) == 0);
      clear = ($urandom_range(0, 63) == 0);
      #1;
      total++; if (in_ready !== !loaded) begin bad++; $display("FAIL rnd_in_ready n=%0d got=%b want=%b", n, in_ready, !loaded); end
      total++; if (input_ready !== loaded) begin bad++; $display("FAIL rnd_input_ready n=%0d got=%b want=%b", n, input_ready, loaded); end
      total++; if (frame_error !== err) begin bad++; $display("FAIL rnd_frame_error n=%0d got=%b want=%b", n, frame_error, err); end
      d = first_diff();
      total++; if (d >= 0) begin bad++; $display("FAIL rnd_vec n=%0d idx=%0d got=%h want=%h", n, d, inputs[d], exp_vec[d]); end
      tick();
      if (clear) begin
        q.delete();
        loaded = 1'b0;
        err = 1'b0;
        zero_exp();
      end else if (loaded) begin
        if (consumer_done) loaded = 1'b0;
      end else if (in_valid) begin
        q.push_back(in_data);
        exp_vec[q.size() - 1] = in_data;
`ifdef NEURON_INPUT_BUFFER_SHORT_FRAME_EN
        if (in_last) begin
          for (int i = q.size(); i < N; i++) exp_vec[i] = '0;
        end
        if (in_last || q.size() == N) begin
          loaded = 1'b1;
          q.delete();
        end
`else
        if (in_last && q.size() != N) err = 1'b1;
        if (q.size() == N) begin
          loaded = 1'b1;
          q.delete();
        end
`endif
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    zero_exp();
    test_reset();
    test_full_frame();
    test_loaded_hold();
    test_gapped();
    test_clear();
    test_last();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
